ex_branch_resolve_stage: RTL and testbench

- Sits directly downstream of the 32-bit Kogge-Stone adder in the EXE stage.
- Consumes the adder's sum and N/Z/C/V flags, resolves conditional branches and jumps, and produces one registered front-end redirect per taken control transfer.
- Squashes wrong-path instructions for a fixed window after each redirect.
- Holds the EX/MEM pipeline register, with a valid/ready handshake toward MEM.

---
 rtl/exe_pkg.sv | 21 ++
 rtl/ex_branch_resolve_stage_if.sv | 63 ++++++
 rtl/branch_cond.sv | 29 ++
 rtl/ex_branch_resolve_stage.sv | 159 +++++++++++++++
 tb/tb_ex_branch_resolve_stage.sv | 306 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/exe_pkg.sv
// rtl/exe_pkg.sv - shared EXE-stage encodings and types
// Purpose: branch funct3 encodings, branch-resolve FSM state type and the
//          default datapath width, shared by the EXE-stage modules.
// Ports:   none (package)
package exe_pkg;

    localparam int XLEN_DEFAULT = 32;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    typedef enum logic {
        RUN    = 1'b0,
        SQUASH = 1'b1
    } state_t;

endpackage

// File: rtl/ex_branch_resolve_stage_if.sv
// rtl/ex_branch_resolve_stage_if.sv - EX input / EX-MEM output bus of the branch resolve stage
// Purpose: bundles the EX instruction beat, adder result/flags, flush, the
//          EX/MEM entry with its handshake, and the front-end redirect.
// Ports:   master = environment (drives the EX beat, flush, out_ready)
//          slave  = ex_branch_resolve_stage (drives in_ready, out_*, redirect_*)
interface ex_branch_resolve_stage_if #(
    parameter int XLEN = 32
);
    logic            in_valid;
    logic            in_ready;
    logic [XLEN-1:0] in_pc;
    logic [XLEN-1:0] in_imm;
    logic [2:0]      in_funct3;
    logic            in_is_branch;
    logic            in_is_jal;
    logic            in_is_jalr;
    logic [4:0]      in_rd;
    logic            in_reg_write;
    logic            in_mem_read;
    logic            in_mem_write;
    logic [XLEN-1:0] in_store_data;
    logic [XLEN-1:0] alu_sum;
    logic            flag_n;
    logic            flag_z;
    logic            flag_c;
    logic            flag_v;
    logic            flush;

    logic            out_valid;
    logic            out_ready;
    logic [XLEN-1:0] out_result;
    logic [XLEN-1:0] out_store_data;
    logic [4:0]      out_rd;
    logic            out_reg_write;
    logic            out_mem_read;
    logic            out_mem_write;
    logic [2:0]      out_funct3;
    logic            out_misalign;

    logic            redirect_valid;
    logic [XLEN-1:0] redirect_pc;

    modport master (
        output in_valid, in_pc, in_imm, in_funct3, in_is_branch, in_is_jal,
               in_is_jalr, in_rd, in_reg_write, in_mem_read, in_mem_write,
               in_store_data, alu_sum, flag_n, flag_z, flag_c, flag_v, flush,
               out_ready,
        input  in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_funct3,
               out_misalign, redirect_valid, redirect_pc
    );

    modport slave (
        input  in_valid, in_pc, in_imm, in_funct3, in_is_branch, in_is_jal,
               in_is_jalr, in_rd, in_reg_write, in_mem_read, in_mem_write,
               in_store_data, alu_sum, flag_n, flag_z, flag_c, flag_v, flush,
               out_ready,
        output in_ready, out_valid, out_result, out_store_data, out_rd,
               out_reg_write, out_mem_read, out_mem_write, out_funct3,
               out_misalign, redirect_valid, redirect_pc
    );

endinterface

// File: rtl/branch_cond.sv
// rtl/branch_cond.sv - conditional branch evaluation from adder flags
// Purpose: decides whether a conditional branch is taken from the flags of
//          rs1-rs2 (C=1 means no borrow, i.e. rs1>=rs2 unsigned).
// Ports:   funct3 in 3, flag_n/z/c/v in 1 each, taken out 1
module branch_cond
    import exe_pkg::*;
(
    input  logic [2:0] funct3,
    input  logic       flag_n,
    input  logic       flag_z,
    input  logic       flag_c,
    input  logic       flag_v,
    output logic       taken
);

    always_comb begin
        taken = 1'b0;
        case (funct3)
            F3_BEQ:  taken = flag_z;
            F3_BNE:  taken = !flag_z;
            F3_BLT:  taken = flag_n ^ flag_v;
            F3_BGE:  taken = !(flag_n ^ flag_v);
            F3_BLTU: taken = !flag_c;
            F3_BGEU: taken = flag_c;
            default: taken = 1'b0;   // 010/011 are not branch encodings
        endcase
    end

endmodule

// File: rtl/ex_branch_resolve_stage.sv
// rtl/ex_branch_resolve_stage.sv - EXE branch resolution, redirect and EX/MEM register
// Purpose: resolves branches/jumps from the adder result, emits one registered
//          redirect per taken aligned transfer, discards SQUASH_CYCLES accepted
//          wrong-path beats afterwards, and holds the EX/MEM entry.
// Ports:   clk, rst (sync active-high), bus (ex_branch_resolve_stage_if.slave)
module ex_branch_resolve_stage
    import exe_pkg::*;
#(
    parameter int XLEN          = XLEN_DEFAULT,
    parameter int SQUASH_CYCLES = 2
) (
    input  logic                          clk,
    input  logic                          rst,
    ex_branch_resolve_stage_if.slave      bus
);

    localparam logic [3:0] SQ_LOAD = 4'(SQUASH_CYCLES);

    state_t          state_q, state_d;
    logic [3:0]      cnt_q, cnt_d;

    logic            out_valid_q;
    logic [XLEN-1:0] out_result_q;
    logic [XLEN-1:0] out_store_data_q;
    logic [4:0]      out_rd_q;
    logic            out_reg_write_q;
    logic            out_mem_read_q;
    logic            out_mem_write_q;
    logic [2:0]      out_funct3_q;
    logic            out_misalign_q;
    logic            redirect_valid_q;
    logic [XLEN-1:0] redirect_pc_q;

    logic            ready;
    logic            accept;
    logic            cond;
    logic            taken;
    logic            is_jump;
    logic [XLEN-1:0] target;
    logic            misalign;
    logic            squashing;
    logic            write_now;
    logic            redirect_now;

    branch_cond u_branch_cond (
        .funct3 (bus.in_funct3),
        .flag_n (bus.flag_n),
        .flag_z (bus.flag_z),
        .flag_c (bus.flag_c),
        .flag_v (bus.flag_v),
        .taken  (cond)
    );

    // Ready depends only on the output slot, never on FSM state or flush.
    assign ready  = !out_valid_q || bus.out_ready;
    assign accept = bus.in_valid && ready;

    assign is_jump  = bus.in_is_jal || bus.in_is_jalr;
    assign taken    = (bus.in_is_branch && cond) || is_jump;
    assign target   = bus.in_is_jalr ? (bus.alu_sum & ~XLEN'(1))
                                     : (bus.in_pc + bus.in_imm);
    assign misalign = taken && (target[1:0] != 2'b00);

    assign squashing    = (state_q == SQUASH);
    assign write_now    = accept && !squashing;
    assign redirect_now = write_now && taken && !misalign;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= RUN;
            cnt_q   <= 4'd0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (bus.flush) begin
            state_d = RUN;
            cnt_d   = 4'd0;
        end else if (accept) begin
            case (state_q)
                RUN: begin
                    if (redirect_now) begin
                        state_d = SQUASH;
                        cnt_d   = SQ_LOAD;
                    end
                end
                SQUASH: begin
                    // Only consumed beats count down the wrong-path window.
                    cnt_d = cnt_q - 4'd1;
                    if (cnt_q == 4'd1) begin
                        state_d = RUN;
                    end
                end
                default: begin
                    state_d = RUN;
                    cnt_d   = 4'd0;
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            out_valid_q      <= 1'b0;
            out_result_q     <= '0;
            out_store_data_q <= '0;
            out_rd_q         <= 5'd0;
            out_reg_write_q  <= 1'b0;
            out_mem_read_q   <= 1'b0;
            out_mem_write_q  <= 1'b0;
            out_funct3_q     <= 3'd0;
            out_misalign_q   <= 1'b0;
            redirect_valid_q <= 1'b0;
            redirect_pc_q    <= '0;
        end else if (bus.flush) begin
            // Entry payload is left as-is; only validity is killed.
            out_valid_q      <= 1'b0;
            redirect_valid_q <= 1'b0;
        end else begin
            redirect_valid_q <= redirect_now;
            if (redirect_now) begin
                redirect_pc_q <= target;
            end
            if (write_now) begin
                out_valid_q      <= 1'b1;
                out_result_q     <= is_jump ? (bus.in_pc + XLEN'(4)) : bus.alu_sum;
                out_store_data_q <= bus.in_store_data;
                out_rd_q         <= bus.in_rd;
                out_reg_write_q  <= bus.in_reg_write && !misalign;
                out_mem_read_q   <= bus.in_mem_read;
                out_mem_write_q  <= bus.in_mem_write;
                out_funct3_q     <= bus.in_funct3;
                out_misalign_q   <= misalign;
            end else if (bus.out_ready) begin
                // Covers both a drained entry and a squashed beat replacing it.
                out_valid_q <= 1'b0;
            end
        end
    end

    assign bus.in_ready       = ready;
    assign bus.out_valid      = out_valid_q;
    assign bus.out_result     = out_result_q;
    assign bus.out_store_data = out_store_data_q;
    assign bus.out_rd         = out_rd_q;
    assign bus.out_reg_write  = out_reg_write_q;
    assign bus.out_mem_read   = out_mem_read_q;
    assign bus.out_mem_write  = out_mem_write_q;
    assign bus.out_funct3     = out_funct3_q;
    assign bus.out_misalign   = out_misalign_q;
    assign bus.redirect_valid = redirect_valid_q;
    assign bus.redirect_pc    = redirect_pc_q;

endmodule

// File: tb/tb_ex_branch_resolve_stage.sv
// tb/tb_ex_branch_resolve_stage.sv - self-checking bench for ex_branch_resolve_stage
module tb_ex_branch_resolve_stage;
    import exe_pkg::*;

    localparam int SQ = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    ex_branch_resolve_stage_if #(.XLEN(32)) bus ();

    ex_branch_resolve_stage #(.XLEN(32), .SQUASH_CYCLES(SQ)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int checks   = 0;
    int failures = 0;

    // Operands behind the current beat: kind 0=alu 1=branch 2=jal 3=jalr
    int          cur_kind = 0;
    logic [31:0] cur_a    = '0;
    logic [31:0] cur_b    = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=0x%08h required=0x%08h", name, act, exp);
        end
    endtask

    // Reference model: decisions from the operand values themselves
    bit          m_known = 0;
    bit          m_valid, m_rw, m_mr, m_mw, m_mis, m_redir;
    logic [31:0] m_result, m_store, m_rpc;
    logic [4:0]  m_rd;
    logic [2:0]  m_f3;
    int          m_sq;

    function automatic bit br_taken(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
        case (f3)
            3'b000:  return a == b;
            3'b001:  return a != b;
            3'b100:  return $signed(a) <  $signed(b);
            3'b101:  return $signed(a) >= $signed(b);
            3'b110:  return a <  b;
            3'b111:  return a >= b;
            default: return 1'b0;
        endcase
    endfunction

    task automatic model_step();
        bit          acc, tk, mis;
        logic [31:0] tgt;
        if (rst) begin
            m_known = 1; m_valid = 0; m_rw = 0; m_mr = 0; m_mw = 0; m_mis = 0;
            m_redir = 0; m_result = '0; m_store = '0; m_rpc = '0; m_rd = '0;
            m_f3 = '0; m_sq = 0;
        end else if (!m_known) begin
            m_known = 0;
        end else if (bus.flush) begin
            m_valid = 0; m_redir = 0; m_sq = 0;
        end else begin
            acc     = bus.in_valid && (!m_valid || bus.out_ready);
            m_redir = 0;
            if (acc && m_sq > 0) begin
                m_sq--;
                m_valid = 0;
            end else if (acc) begin
                tk  = (cur_kind >= 2) || (cur_kind == 1 && br_taken(bus.in_funct3, cur_a, cur_b));
                tgt = (cur_kind == 3) ? ((cur_a + bus.in_imm) & 32'hFFFF_FFFE) : (bus.in_pc + bus.in_imm);
                mis = tk && (tgt[1:0] != 2'b00);
                m_valid  = 1;
                m_result = (cur_kind == 0) ? cur_a : (cur_kind == 1) ? (cur_a - cur_b) : (bus.in_pc + 32'd4);
                m_store  = bus.in_store_data;
                m_rd     = bus.in_rd;
                m_rw     = bus.in_reg_write && !mis;
                m_mr     = bus.in_mem_read;
                m_mw     = bus.in_mem_write;
                m_f3     = bus.in_funct3;
                m_mis    = mis;
                if (tk && !mis) begin
                    m_redir = 1; m_rpc = tgt; m_sq = SQ;
                end
            end else if (bus.out_ready) begin
                m_valid = 0;
            end
        end
    endtask

    bit prev_redir = 0;
    always @(negedge clk) begin
        if (m_known) begin
            chk("m_in_ready",       {31'd0, bus.in_ready},       {31'd0, (!m_valid || bus.out_ready)});
            chk("m_out_valid",      {31'd0, bus.out_valid},      {31'd0, m_valid});
            chk("m_redirect_valid", {31'd0, bus.redirect_valid}, {31'd0, m_redir});
            chk("m_redirect_pc",    bus.redirect_pc,    m_rpc);
            chk("m_out_result",     bus.out_result,     m_result);
            chk("m_out_store_data", bus.out_store_data, m_store);
            chk("m_out_rd",         {27'd0, bus.out_rd},     {27'd0, m_rd});
            chk("m_out_funct3",     {29'd0, bus.out_funct3}, {29'd0, m_f3});
            chk("m_out_ctl", {28'd0, bus.out_reg_write, bus.out_mem_read, bus.out_mem_write, bus.out_misalign},
                             {28'd0, m_rw, m_mr, m_mw, m_mis});
            if (prev_redir) chk("m_redirect_back_to_back", {31'd0, bus.redirect_valid}, 32'd0);
            prev_redir = bus.redirect_valid;
        end
        model_step();
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        bus.in_valid = 1'b0;
    endtask

    // Emulates the upstream adder so flags always match the operands.
    task automatic drive(input int kind, input logic [2:0] f3, input logic [31:0] a,
                         input logic [31:0] b, input logic [31:0] pc, input logic [31:0] imm,
                         input logic rw);
        logic [31:0] s;
        cur_kind = kind; cur_a = a; cur_b = b;
        bus.in_valid      = 1'b1;
        bus.in_pc         = pc;
        bus.in_imm        = imm;
        bus.in_funct3     = f3;
        bus.in_is_branch  = (kind == 1);
        bus.in_is_jal     = (kind == 2);
        bus.in_is_jalr    = (kind == 3);
        bus.in_rd         = 5'($urandom);
        bus.in_reg_write  = rw;
        bus.in_mem_read   = 1'($urandom);
        bus.in_mem_write  = 1'($urandom);
        bus.in_store_data = $urandom;
        if (kind == 1) begin
            s = a - b;
            bus.alu_sum = s;
            bus.flag_n  = s[31];
            bus.flag_z  = (s == 32'd0);
            bus.flag_c  = (a >= b);
            bus.flag_v  = (a[31] != b[31]) && (s[31] != a[31]);
        end else begin
            bus.alu_sum = (kind == 3) ? (a + imm) : (kind == 0) ? a : $urandom;
            bus.flag_n  = 1'($urandom);
            bus.flag_z  = 1'($urandom);
            bus.flag_c  = 1'($urandom);
            bus.flag_v  = 1'($urandom);
        end
    endtask

    task automatic alu(input logic [31:0] v);
        drive(0, 3'b010, v, 32'd0, 32'h0, 32'h0, 1'b1);
    endtask

    task automatic fillers();
        for (int i = 0; i < SQ; i++) begin
            alu(32'hF111_0000 + 32'(i));
            step();
        end
    endtask

    initial begin
        bus.flush = 1'b0;
        bus.out_ready = 1'b1;
        alu(32'h0);
        idle();
        rst = 1'b1;
        step(); step();
        chk("reset_out_valid", {31'd0, bus.out_valid}, 32'd0);
        chk("reset_redirect",  {31'd0, bus.redirect_valid}, 32'd0);
        chk("reset_result",    bus.out_result, 32'd0);
        rst = 1'b0;
        step();
        chk("reset_in_ready",  {31'd0, bus.in_ready}, 32'd1);

        // BEQ taken, two squashed beats, third one lands
        drive(1, F3_BEQ, 32'd5, 32'd5, 32'h100, 32'h20, 1'b0);
        step();
        chk("beq_redirect_valid", {31'd0, bus.redirect_valid}, 32'd1);
        chk("beq_redirect_pc",    bus.redirect_pc, 32'h120);
        alu(32'hA);  step();
        chk("beq_pulse_one_cycle", {31'd0, bus.redirect_valid}, 32'd0);
        chk("beq_squash1", {31'd0, bus.out_valid}, 32'd0);
        alu(32'hB);  step();
        chk("beq_squash2", {31'd0, bus.out_valid}, 32'd0);
        alu(32'hC0FFEE); step();
        chk("beq_third_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("beq_third_result", bus.out_result, 32'hC0FFEE);

        // BLTU taken / BGEU not taken on 0x1-0x10
        drive(1, F3_BLTU, 32'h1, 32'h10, 32'h400, 32'h8, 1'b0);
        step();
        chk("bltu_taken", {31'd0, bus.redirect_valid}, 32'd1);
        chk("bltu_pc", bus.redirect_pc, 32'h408);
        fillers();
        drive(1, F3_BGEU, 32'h1, 32'h10, 32'h400, 32'h8, 1'b0);
        step();
        chk("bgeu_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("bgeu_out_valid",   {31'd0, bus.out_valid}, 32'd1);
        chk("bgeu_result",      bus.out_result, 32'hFFFF_FFF1);
        alu(32'h1234); step();
        chk("bgeu_stays_run", bus.out_result, 32'h1234);

        // Overflow case: BLT not taken, BGE taken
        drive(1, F3_BLT, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h500, 32'h10, 1'b0);
        step();
        chk("blt_ovf_not_taken", {31'd0, bus.redirect_valid}, 32'd0);
        drive(1, F3_BGE, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h500, 32'h10, 1'b0);
        step();
        chk("bge_ovf_taken", {31'd0, bus.redirect_valid}, 32'd1);
        chk("bge_ovf_pc",    bus.redirect_pc, 32'h510);
        fillers();

        // JALR and misaligned JAL
        drive(3, 3'b000, 32'h1000, 32'h0, 32'h200, 32'h5, 1'b1);
        step();
        chk("jalr_pc",     bus.redirect_pc, 32'h1004);
        chk("jalr_result", bus.out_result, 32'h204);
        chk("jalr_rw",     {31'd0, bus.out_reg_write}, 32'd1);
        fillers();
        drive(2, 3'b000, 32'h0, 32'h0, 32'h100, 32'h2, 1'b1);
        step();
        chk("jal_misalign",    {31'd0, bus.out_misalign}, 32'd1);
        chk("jal_no_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("jal_rw_cleared",  {31'd0, bus.out_reg_write}, 32'd0);

        // Backpressure: hold for 3 cycles, then drain and accept together
        alu(32'h11); step();
        bus.out_ready = 1'b0;
        alu(32'h22);
        for (int i = 0; i < 3; i++) begin
            step();
            chk("bp_in_ready", {31'd0, bus.in_ready}, 32'd0);
            chk("bp_hold",     bus.out_result, 32'h11);
            chk("bp_valid",    {31'd0, bus.out_valid}, 32'd1);
        end
        bus.out_ready = 1'b1;
        #1;
        chk("bp_release_ready", {31'd0, bus.in_ready}, 32'd1);
        step();
        chk("bp_new_entry", bus.out_result, 32'h22);
        chk("bp_new_valid", {31'd0, bus.out_valid}, 32'd1);

        // Reset with one squash beat still pending
        drive(1, F3_BEQ, 32'd9, 32'd9, 32'h300, 32'h40, 1'b0);
        step();
        alu(32'h33); step();
        rst = 1'b1;
        alu(32'h44); step();
        chk("rst_sq_valid",    {31'd0, bus.out_valid}, 32'd0);
        chk("rst_sq_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("rst_sq_result",   bus.out_result, 32'd0);
        chk("rst_sq_rpc",      bus.redirect_pc, 32'd0);
        rst = 1'b0;
        alu(32'h55); step();
        chk("rst_first_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("rst_first_result", bus.out_result, 32'h55);

        // Flush during backpressure, then flush beating a redirect
        alu(32'h66); step();
        bus.out_ready = 1'b0;
        idle();
        bus.flush = 1'b1;
        step();
        chk("flush_bp_valid", {31'd0, bus.out_valid}, 32'd0);
        bus.out_ready = 1'b1;
        drive(1, F3_BEQ, 32'd1, 32'd1, 32'h600, 32'h4, 1'b0);
        step();
        chk("flush_redirect", {31'd0, bus.redirect_valid}, 32'd0);
        chk("flush_drop",     {31'd0, bus.out_valid}, 32'd0);
        bus.flush = 1'b0;
        alu(32'h77); step();
        chk("flush_run_valid",  {31'd0, bus.out_valid}, 32'd1);
        chk("flush_run_result", bus.out_result, 32'h77);

        // Randomized traffic against the model
        for (int n = 0; n < 4000; n++) begin
            int          k;
            logic [31:0] a, b, pc, imm;
            k   = int'($urandom_range(0, 3));
            a   = ($urandom_range(0, 3) == 0) ? 32'h8000_0000 ^ 32'($urandom_range(0, 3)) : $urandom;
            b   = ($urandom_range(0, 2) == 0) ? a : $urandom;
            pc  = {20'd0, 10'($urandom), 2'b00};
            imm = {22'd0, 8'($urandom), ($urandom_range(0, 4) == 0) ? 2'($urandom) : 2'b00};
            drive(k, 3'($urandom), a, b, pc, imm, 1'($urandom));
            bus.in_valid  = ($urandom_range(0, 9) < 7);
            bus.out_ready = ($urandom_range(0, 9) < 7);
            bus.flush     = ($urandom_range(0, 19) == 0);
            rst           = ($urandom_range(0, 199) == 0);
            step();
        end
        rst = 1'b0;
        bus.flush = 1'b0;
        idle();
        step(); step();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
